// File: rtl/tmds_lane_decoder.sv
// ---------------------------------------------------------------------------
// tmds_lane_decoder
//
// Receive-side decoder for one DVI TMDS lane. Raw 10-bit words arrive once
// per pixel clock from a deserializer whose word boundary is arbitrary. The
// block looks at a 10-bit window sliding over two consecutive raw words,
// hunts for the bit offset at which a run of control tokens appears, then
// decodes every symbol at that offset into either 8-bit pixel data or a
// 2-bit control value.
//
// Optional feature (macro TMDS_DECODER_ERRCNT_EN):
//   When defined, data symbols decoded while locked are checked against
//   the encoder's XOR/XNOR selection rule and violations are counted on
//   out_errors (saturating, cleared on reset and whenever lock is lost).
//   When undefined, out_errors is tied to zero and no checker exists.
//
// Parameters:
//   C_token_run    consecutive control tokens needed to declare lock
//   C_timeout      pixel clocks without a control token before slipping
//                  one bit (hunting) or dropping lock (locked)
//   C_timeout_bits width of the timeout counter (C_timeout < 2**bits)
//
// Ports:
//   clk_pixel   in   1   pixel clock, rising edge
//   reset       in   1   asynchronous active-high reset
//   in_symbol   in  10   raw word, bit0 received first
//   out_data    out  8   decoded pixel data (valid when out_de=1)
//   out_c       out  2   decoded control bits {c1,c0} (valid when out_de=0)
//   out_de      out  1   1 = data symbol, 0 = control token
//   out_locked  out  1   symbol alignment achieved
//   out_slip    out  4   current bit offset 0..9
//   out_errors  out 16   encoding-rule violation count
//
// Pipeline:
//   cycle 0 : window formed from {in_symbol, r_prev} at offset r_slip
//   stage 1 : window registered in r_s1_word (qualified by r_s1_valid)
//   stage 2 : r_s1_word decoded into the registered outputs; the token and
//             timeout counters and the alignment FSM act on the same word,
//             so out_locked moves together with the output it qualifies.
//
// Handshake: there is no back-pressure. Every pixel clock carries one word
// in and one decoded symbol out; downstream qualifies the outputs with
// out_locked (and out_de to choose data versus control).
// ---------------------------------------------------------------------------
module tmds_lane_decoder #(
  parameter int C_token_run    = 8,
  parameter int C_timeout      = 4095,
  parameter int C_timeout_bits = 12
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  in_symbol,
  output logic [7:0]  out_data,
  output logic [1:0]  out_c,
  output logic        out_de,
  output logic        out_locked,
  output logic [3:0]  out_slip,
  output logic [15:0] out_errors
);

  localparam int C_tok_bits = $clog2(C_token_run + 1);
  localparam logic [C_tok_bits-1:0]     C_tok_max = C_tok_bits'(C_token_run);
  localparam logic [C_timeout_bits-1:0] C_to_max  = C_timeout_bits'(C_timeout);

  // Control token encodings, written as w[9:0].
  localparam logic [9:0] C_ctl0 = 10'b1101010100;
  localparam logic [9:0] C_ctl1 = 10'b0010101011;
  localparam logic [9:0] C_ctl2 = 10'b0101010100;
  localparam logic [9:0] C_ctl3 = 10'b1010101011;

  typedef enum logic {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t                    r_state;
  logic [3:0]                r_slip;
  logic [9:0]                r_prev;
  logic [9:0]                r_s1_word;
  logic                      r_s1_valid;
  logic [C_tok_bits-1:0]     r_tok_cnt;
  logic [C_timeout_bits-1:0] r_to_cnt;
  logic [7:0]                r_data;
  logic [1:0]                r_c;
  logic                      r_de;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic [9:0]                w_win;
  logic                      w_is_tok;
  logic [1:0]                w_tok_c;
  logic [7:0]                w_d;
  logic [7:0]                w_dec;
  logic                      w_tok_valid;
  logic                      w_dat_valid;
  logic [C_tok_bits-1:0]     w_tok_next;
  logic [C_timeout_bits-1:0] w_to_next;
  logic                      w_expire;
  state_t                    w_state_nxt;
  logic [3:0]                w_slip_nxt;
  logic                      w_slip_evt;
  logic                      w_hunt_entry;

  // -------------------------------------------------------------------------
  // Window selection: bits [slip+9:slip] of {in_symbol, r_prev}. r_prev is
  // the older word, so its bits are the earlier-received ones.
  // -------------------------------------------------------------------------
  always_comb begin
    w_win = r_prev;
    case (r_slip)
      4'd0:    w_win = r_prev;
      4'd1:    w_win = {in_symbol[0],   r_prev[9:1]};
      4'd2:    w_win = {in_symbol[1:0], r_prev[9:2]};
      4'd3:    w_win = {in_symbol[2:0], r_prev[9:3]};
      4'd4:    w_win = {in_symbol[3:0], r_prev[9:4]};
      4'd5:    w_win = {in_symbol[4:0], r_prev[9:5]};
      4'd6:    w_win = {in_symbol[5:0], r_prev[9:6]};
      4'd7:    w_win = {in_symbol[6:0], r_prev[9:7]};
      4'd8:    w_win = {in_symbol[7:0], r_prev[9:8]};
      4'd9:    w_win = {in_symbol[8:0], r_prev[9]};
      default: w_win = r_prev;
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage-2 symbol classification and decode
  // -------------------------------------------------------------------------
  always_comb begin
    w_is_tok = 1'b1;
    w_tok_c  = 2'b00;
    case (r_s1_word)
      C_ctl0:  w_tok_c = 2'b00;
      C_ctl1:  w_tok_c = 2'b01;
      C_ctl2:  w_tok_c = 2'b10;
      C_ctl3:  w_tok_c = 2'b11;
      default: w_is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9), then undo the XOR (bit 8 = 1) or
  // XNOR (bit 8 = 0) chain the encoder applied.
  always_comb begin
    w_d      = r_s1_word[9] ? ~r_s1_word[7:0] : r_s1_word[7:0];
    w_dec    = 8'h00;
    w_dec[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      w_dec[i] = r_s1_word[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    end
  end

  // -------------------------------------------------------------------------
  // Token and timeout counters (next values). A stage-1 word that was
  // captured just before a slip carries the old alignment and is ignored.
  // -------------------------------------------------------------------------
  assign w_tok_valid = r_s1_valid & w_is_tok;
  assign w_dat_valid = r_s1_valid & ~w_is_tok;

  always_comb begin
    w_tok_next = r_tok_cnt;
    if (w_tok_valid) begin
      w_tok_next = (r_tok_cnt == C_tok_max) ? r_tok_cnt : r_tok_cnt + 1'b1;
    end else if (w_dat_valid) begin
      w_tok_next = '0;
    end
  end

  always_comb begin
    w_to_next = r_to_cnt;
    if (w_tok_valid) begin
      w_to_next = '0;
    end else if (w_dat_valid) begin
      w_to_next = (r_to_cnt == C_to_max) ? r_to_cnt : r_to_cnt + 1'b1;
    end
  end

  // Expiry only on a data symbol, so a token landing on the expiry cycle
  // wins: it clears the timeout and no slip happens.
  assign w_expire = w_dat_valid && (w_to_next == C_to_max);

  // -------------------------------------------------------------------------
  // Alignment FSM
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_slip_nxt   = r_slip;
    w_slip_evt   = 1'b0;
    w_hunt_entry = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (w_tok_valid && (w_tok_next == C_tok_max)) begin
          w_state_nxt = S_LOCKED;
        end else if (w_expire) begin
          w_slip_evt = 1'b1;
          w_slip_nxt = (r_slip == 4'd9) ? 4'd0 : r_slip + 4'd1;
        end
      end
      S_LOCKED: begin
        // Slip stays frozen; hunting later resumes from this offset.
        if (w_expire) begin
          w_state_nxt  = S_HUNT;
          w_hunt_entry = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_state <= S_HUNT;
      r_slip  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_slip  <= w_slip_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_prev     <= 10'd0;
      r_s1_word  <= 10'd0;
      r_s1_valid <= 1'b0;
      r_tok_cnt  <= '0;
      r_to_cnt   <= '0;
      r_data     <= 8'h00;
      r_c        <= 2'b00;
      r_de       <= 1'b0;
    end else begin
      r_prev     <= in_symbol;
      r_s1_word  <= w_win;
      r_s1_valid <= ~w_slip_evt;
      r_tok_cnt  <= w_slip_evt ? '0 : w_tok_next;
      r_to_cnt   <= (w_slip_evt || w_hunt_entry) ? '0 : w_to_next;
      if (w_tok_valid) begin
        r_c  <= w_tok_c;
        r_de <= 1'b0;
      end else if (w_dat_valid) begin
        r_data <= w_dec;
        r_de   <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Encoding-rule violation counter
  // -------------------------------------------------------------------------
`ifdef TMDS_DECODER_ERRCNT_EN
  logic [15:0] r_errors;
  logic [3:0]  w_pop;
  logic        w_xnor_exp;
  logic        w_err;

  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'b000, w_dec[i]};
    end
  end

  // The encoder picks XNOR (bit 8 = 0) for popcount > 4, or == 4 with a
  // zero LSB; a received bit 8 equal to that XNOR flag is a violation.
  assign w_xnor_exp = (w_pop > 4'd4) || ((w_pop == 4'd4) && !w_dec[0]);
  assign w_err      = w_dat_valid && (r_state == S_LOCKED) &&
                      (r_s1_word[8] == w_xnor_exp);

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_errors <= 16'h0000;
    end else if (w_hunt_entry) begin
      r_errors <= 16'h0000;
    end else if (w_err && (r_errors != 16'hFFFF)) begin
      r_errors <= r_errors + 16'h0001;
    end
  end

  assign out_errors = r_errors;
`else
  assign out_errors = 16'h0000;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_data   = r_data;
  assign out_c      = r_c;
  assign out_de     = r_de;
  assign out_locked = (r_state == S_LOCKED);
  assign out_slip   = r_slip;

endmodule

// File: tb/tb_tmds_lane_decoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_lane_decoder
//
// Directed bench for tmds_lane_decoder with a short timeout (15) so slips
// and lock loss happen within a few dozen clocks. Inputs change 1 time unit
// after the rising edge and outputs are sampled at the same point, away
// from the active edge.
// ---------------------------------------------------------------------------
module tb_tmds_lane_decoder;

  localparam logic [9:0] CTL0  = 10'b1101010100;
  localparam logic [9:0] CTL1  = 10'b0010101011;
  localparam logic [9:0] CTL2  = 10'b0101010100;
  localparam logic [9:0] CTL3  = 10'b1010101011;
  localparam logic [9:0] D_A5  = 10'h163;  // 8'hA5, XOR, not inverted
  localparam logic [9:0] D_FF  = 10'h0FF;  // 8'hFF, XNOR, not inverted
  localparam logic [9:0] D_00I = 10'h3FF;  // 8'h00, XOR, inverted
  localparam logic [9:0] D_PRE = 10'h100;  // 8'h00, XOR: a single 1 bit
  localparam logic [9:0] D_BAD = 10'h0C9;  // 8'hA5 built with XNOR (rule violation)

`ifdef TMDS_DECODER_ERRCNT_EN
  localparam logic [15:0] EXP_ERR5 = 16'd5;
`else
  localparam logic [15:0] EXP_ERR5 = 16'd0;
`endif

  logic        clk_pixel;
  logic        reset;
  logic [9:0]  in_symbol;
  logic [7:0]  out_data;
  logic [1:0]  out_c;
  logic        out_de;
  logic        out_locked;
  logic [3:0]  out_slip;
  logic [15:0] out_errors;

  logic [9:0]  tx_prev;
  logic [3:0]  last_slip;
  int          n_checks;
  int          n_errors;

  tmds_lane_decoder #(
    .C_token_run    (8),
    .C_timeout      (15),
    .C_timeout_bits (4)
  ) dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .in_symbol  (in_symbol),
    .out_data   (out_data),
    .out_c      (out_c),
    .out_de     (out_de),
    .out_locked (out_locked),
    .out_slip   (out_slip),
    .out_errors (out_errors)
  );

  // Clock / reset
  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic do_reset();
    reset     = 1'b1;
    in_symbol = 10'd0;
    tx_prev   = 10'd0;
    repeat (3) @(posedge clk_pixel);
    #1;
    reset = 1'b0;
  endtask

  // Send one symbol on a serial stream whose words are cut so that the
  // decoder recovers the symbol at bit offset 'rot'. Returns 1 unit after
  // the edge that captured the word.
  task automatic send(input logic [9:0] sym, input int rot);
    logic [19:0] cat;
    cat       = {sym, tx_prev} >> (10 - rot);
    in_symbol = cat[9:0];
    tx_prev   = sym;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic send_n(input logic [9:0] sym, input int rot, input int n);
    for (int i = 0; i < n; i++) send(sym, rot);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // ---- reset values --------------------------------------------------
    do_reset();
    check("rst_data",   16'(out_data),   16'h0);
    check("rst_c",      16'(out_c),      16'h0);
    check("rst_de",     16'(out_de),     16'h0);
    check("rst_locked", 16'(out_locked), 16'h0);
    check("rst_slip",   16'(out_slip),   16'h0);
    check("rst_errors", out_errors,      16'h0);

    // ---- aligned lock: 8th token reaches the outputs on step 10 -------
    send_n(CTL0, 0, 9);
    check("lock_early", 16'(out_locked), 16'h0);
    send(CTL0, 0);
    check("lock_on",    16'(out_locked), 16'h1);
    check("lock_slip",  16'(out_slip),   16'h0);
    check("lock_c",     16'(out_c),      16'h0);
    check("lock_de",    16'(out_de),     16'h0);

    // ---- data A5 appears exactly two clocks after capture -------------
    send(D_A5, 0);
    send(CTL2, 0);
    check("a5_not_yet", 16'(out_de),   16'h0);
    send(CTL2, 0);
    check("a5_data",    16'(out_data), 16'h00A5);
    check("a5_de",      16'(out_de),   16'h1);
    check("a5_c_hold",  16'(out_c),    16'h0);
    send(CTL2, 0);
    check("ctl2_c",     16'(out_c),    16'h2);
    check("ctl2_de",    16'(out_de),   16'h0);
    check("ctl2_dhold", 16'(out_data), 16'h00A5);

    // ---- XNOR data, inverted data, remaining control codes ------------
    send(D_FF, 0);
    send(D_00I, 0);
    send(CTL1, 0);
    check("ff_data",  16'(out_data), 16'h00FF);
    send(CTL3, 0);
    check("inv_data", 16'(out_data), 16'h0000);
    check("inv_de",   16'(out_de),   16'h1);
    send(CTL0, 0);
    check("ctl1_c",   16'(out_c),    16'h1);
    send(CTL0, 0);
    check("ctl3_c",   16'(out_c),    16'h3);
    check("still_locked", 16'(out_locked), 16'h1);

    // ---- HUNT timeout: 15 data symbols (incl. reset word) -> slip -----
    do_reset();
    send_n(D_PRE, 0, 15);
    check("to_before", 16'(out_slip), 16'h0);
    send(D_PRE, 0);
    check("to_slip1",  16'(out_slip), 16'h1);

    // ---- token on the expiry cycle wins; it counts as token #1 --------
    do_reset();
    send_n(D_PRE, 0, 13);
    send_n(CTL0, 0, 3);
    check("tie_noslip", 16'(out_slip),   16'h0);
    send_n(CTL0, 0, 6);
    check("tie_7tok",   16'(out_locked), 16'h0);
    send(CTL0, 0);
    check("tie_8tok",   16'(out_locked), 16'h1);
    check("tie_slip",   16'(out_slip),   16'h0);

    // ---- stream rotated by 3: slip walks 1,2,3 then locks -------------
    do_reset();
    for (int s = 1; s <= 3; s++) begin
      last_slip = out_slip;
      for (int i = 0; i < 40 && out_slip == last_slip; i++) send(D_PRE, 3);
      check("rot_slip_step", 16'(out_slip), 16'(s));
    end
    send_n(CTL0, 3, 12);
    check("rot_locked", 16'(out_locked), 16'h1);
    check("rot_slip",   16'(out_slip),   16'h3);
    check("rot_c",      16'(out_c),      16'h0);

    // ---- data at the recovered offset, then lock loss by timeout ------
    send_n(D_A5, 3, 12);
    check("rot_data",     16'(out_data),   16'h00A5);
    check("rot_de",       16'(out_de),     16'h1);
    check("rot_hold_lck", 16'(out_locked), 16'h1);
    send_n(D_A5, 3, 8);
    check("drop_locked",  16'(out_locked), 16'h0);
    check("drop_slip",    16'(out_slip),   16'h3);
    send_n(CTL0, 3, 12);
    check("relock",       16'(out_locked), 16'h1);
    check("relock_slip",  16'(out_slip),   16'h3);

    // ---- encoding-rule violations while locked ------------------------
    send_n(D_BAD, 3, 5);
    send_n(CTL0, 3, 4);
    check("bad_data",   16'(out_data),   16'h00A5);
    check("err_count",  out_errors,      EXP_ERR5);
    send_n(D_A5, 3, 20);
    check("err_hunt_lck", 16'(out_locked), 16'h0);
    check("err_cleared",  out_errors,      16'h0);

    // ---- asynchronous reset in mid-operation --------------------------
    send_n(CTL3, 3, 12);
    check("pre_rst_lck", 16'(out_locked), 16'h1);
    reset = 1'b1;
    #1;
    check("arst_locked", 16'(out_locked), 16'h0);
    check("arst_slip",   16'(out_slip),   16'h0);
    check("arst_data",   16'(out_data),   16'h0);
    check("arst_c",      16'(out_c),      16'h0);
    check("arst_de",     16'(out_de),     16'h0);
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
